// File: rtl/dram_ctrl_pkg.sv
// dram_ctrl_pkg: shared widths, command codes and FSM encoding for the DRAM request path
package dram_ctrl_pkg;
  function automatic int column_width(input int cols, input int dw);
    return $clog2(cols / dw);
  endfunction
  function automatic int row_width(input int rows);
    return $clog2(rows);
  endfunction
  function automatic int bank_id_width(input int banks);
    return $clog2(banks);
  endfunction
  function automatic int u_addr_width(input int banks, input int rows, input int cols, input int dw);
    return bank_id_width(banks) + row_width(rows) + column_width(cols, dw);
  endfunction
  localparam logic CMD_READ = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR} state_e;
endpackage

// File: rtl/dram_req_fifo.sv
// dram_req_fifo: synchronous FIFO with push/pop and occupancy count, flushed by reset
module dram_req_fifo #(
  parameter int WIDTH = 15,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_d = push ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end
  assign rdata = mem_q[rd_q];
  assign count = count_q;
endmodule

// File: rtl/dram_cmd_queue.sv
// dram_cmd_queue: queues client requests and issues them one at a time to dram_controller
module dram_cmd_queue import dram_ctrl_pkg::*; #(
  parameter int NUMBER_OF_COLUMNS = 8,
  parameter int NUMBER_OF_ROWS = 128,
  parameter int NUMBER_OF_BANKS = 8,
  parameter int U_DATA_WIDTH = 2,
  parameter int DRAM_DATA_WIDTH = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int RD_TIMEOUT = 64,
  parameter int U_ADDR_WIDTH = u_addr_width(NUMBER_OF_BANKS, NUMBER_OF_ROWS, NUMBER_OF_COLUMNS, DRAM_DATA_WIDTH),
  parameter int QW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                    u_clk,
  input  logic                    u_rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [U_ADDR_WIDTH-1:0] req_addr,
  input  logic [U_DATA_WIDTH-1:0] req_wdata,
  input  logic                    req_cmd,
  output logic                    rsp_valid,
  output logic [U_DATA_WIDTH-1:0] rsp_data,
  output logic                    rsp_err,
  output logic                    wr_done,
  output logic [QW-1:0]           q_count,
  output logic                    u_en,
  output logic [U_ADDR_WIDTH-1:0] u_addr,
  output logic [U_DATA_WIDTH-1:0] u_data_i,
  output logic                    u_cmd,
  input  logic [U_DATA_WIDTH-1:0] u_data_o,
  input  logic                    u_data_valid,
  input  logic                    u_cmd_ack,
  input  logic                    u_busy
);
  localparam int EW = 1 + U_ADDR_WIDTH + U_DATA_WIDTH;
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  state_e state_q, state_d;
  logic [EW-1:0] head;
  logic push, pop, load, timeout, rd_done;
  logic en_q, en_d, cmd_q, cmd_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, wr_done_q, wr_done_d;
  logic [U_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [U_DATA_WIDTH-1:0] wdata_q, wdata_d, rsp_data_q, rsp_data_d;
  logic [TW-1:0] cnt_q, cnt_d;
  assign req_ready = u_rst_n && (q_count != QW'(QUEUE_DEPTH));
  assign push = req_valid && req_ready;
  assign pop = state_q == ISSUE && u_cmd_ack;
  assign timeout = cnt_q == TW'(RD_TIMEOUT - 1);
  dram_req_fifo #(.WIDTH(EW), .DEPTH(QUEUE_DEPTH), .CW(QW)) u_fifo (
    .clk(u_clk),
    .rst_n(u_rst_n),
    .push(push),
    .pop(pop),
    .wdata({req_cmd, req_addr, req_wdata}),
    .rdata(head),
    .count(q_count)
  );
  always_ff @(posedge u_clk) begin
    if (!u_rst_n) begin
      state_q <= IDLE;
      en_q <= 1'b0;
      cmd_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      wr_done_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      en_q <= en_d;
      cmd_q <= cmd_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      wr_done_q <= wr_done_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = (q_count != '0 && !u_busy) ? ISSUE : IDLE;
      ISSUE:   state_d = !u_cmd_ack ? ISSUE : (head[EW-1] == CMD_READ ? WAIT_RD : WAIT_WR);
      WAIT_RD: state_d = (u_data_valid || timeout) ? IDLE : WAIT_RD;
      WAIT_WR: state_d = u_busy ? WAIT_WR : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Data beats in the same cycle as the timeout win; the counter parks at its limit.
  always_comb begin
    load = state_q == IDLE && state_d == ISSUE;
    rd_done = state_q == WAIT_RD && (u_data_valid || timeout);
    en_d = state_d == ISSUE;
    {cmd_d, addr_d, wdata_d} = load ? head : {cmd_q, addr_q, wdata_q};
    rsp_valid_d = rd_done;
    rsp_err_d = rd_done ? !u_data_valid : rsp_err_q;
    rsp_data_d = rd_done ? (u_data_valid ? u_data_o : '0) : rsp_data_q;
    wr_done_d = state_q == WAIT_WR && !u_busy;
    cnt_d = pop ? '0 : (state_q == WAIT_RD && !timeout) ? cnt_q + TW'(1) : cnt_q;
  end
  assign u_en = en_q;
  assign u_cmd = cmd_q;
  assign u_addr = addr_q;
  assign u_data_i = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
  assign wr_done = wr_done_q;
endmodule

// File: tb/tb_dram_cmd_queue.sv
// tb_dram_cmd_queue: directed vector table plus hand sequences for queue-full, timeout, overlap and reset
module tb_dram_cmd_queue;
  logic u_clk = 1'b0;
  logic u_rst_n, req_valid, req_ready, req_cmd, rsp_valid, rsp_err, wr_done;
  logic u_en, u_cmd, u_data_valid, u_cmd_ack, u_busy;
  logic [11:0] req_addr, u_addr;
  logic [1:0] req_wdata, rsp_data, u_data_i, u_data_o;
  logic [2:0] q_count;
  int errors = 0;
  int checks = 0;

  always #5 u_clk = ~u_clk;

  dram_cmd_queue dut (
    .u_clk(u_clk), .u_rst_n(u_rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_cmd(req_cmd), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .wr_done(wr_done), .q_count(q_count),
    .u_en(u_en), .u_addr(u_addr), .u_data_i(u_data_i), .u_cmd(u_cmd), .u_data_o(u_data_o),
    .u_data_valid(u_data_valid), .u_cmd_ack(u_cmd_ack), .u_busy(u_busy)
  );

  typedef struct {
    logic rst_n, valid, cmd; logic [11:0] addr; logic [1:0] wdata;
    logic ack, busy, dv; logic [1:0] dout;
    logic en, ecmd; logic [11:0] eaddr; logic rv; logic [1:0] rdata;
    logic rerr, wd; logic [2:0] cnt; logic rdy;
  } vec_t;
  vec_t vec [17];

  task automatic tick();
    @(posedge u_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_en();
    for (int i = 0; i < 20 && !u_en; i++) tick();
    check("issue_en", u_en, 1);
  endtask

  initial begin
    u_rst_n = 0; req_valid = 0; req_cmd = 0; req_addr = 0; req_wdata = 0;
    u_cmd_ack = 0; u_busy = 0; u_data_valid = 0; u_data_o = 0;
    //          rst v c addr    wd ack bsy dv do | en ec eaddr   rv rd er wd cnt rdy
    vec[0]  = '{0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0};
    vec[1]  = '{1, 1, 1, 12'h2A5, 2, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 1, 1};
    vec[2]  = '{1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1, 1, 12'h2A5, 0, 0, 0, 0, 1, 1};
    vec[3]  = '{1, 0, 0, 12'h000, 0, 0, 1, 0, 0, 1, 1, 12'h2A5, 0, 0, 0, 0, 1, 1};
    vec[4]  = '{1, 0, 0, 12'h000, 0, 1, 1, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1};
    vec[5]  = '{1, 0, 0, 12'h000, 0, 0, 1, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1};
    vec[6]  = '{1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 1, 0, 1};
    vec[7]  = '{1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1};
    vec[8]  = '{1, 1, 1, 12'h013, 3, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 1, 1};
    vec[9]  = '{1, 1, 0, 12'h013, 0, 0, 0, 0, 0, 1, 1, 12'h013, 0, 0, 0, 0, 2, 1};
    vec[10] = '{1, 0, 0, 12'h000, 0, 1, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 1, 1};
    vec[11] = '{1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 1, 1, 1};
    vec[12] = '{1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1, 0, 12'h013, 0, 0, 0, 0, 1, 1};
    vec[13] = '{1, 0, 0, 12'h000, 0, 1, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1};
    vec[14] = '{1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1};
    vec[15] = '{1, 0, 0, 12'h000, 0, 0, 0, 1, 3, 0, 0, 12'h000, 1, 3, 0, 0, 0, 1};
    vec[16] = '{1, 0, 0, 12'h000, 0, 0, 0, 1, 2, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 17; i++) begin
      u_rst_n = vec[i].rst_n; req_valid = vec[i].valid; req_cmd = vec[i].cmd;
      req_addr = vec[i].addr; req_wdata = vec[i].wdata; u_cmd_ack = vec[i].ack;
      u_busy = vec[i].busy; u_data_valid = vec[i].dv; u_data_o = vec[i].dout;
      tick();
      check($sformatf("v%0d_en", i), u_en, vec[i].en);
      if (vec[i].en) begin
        check($sformatf("v%0d_cmd", i), u_cmd, vec[i].ecmd);
        check($sformatf("v%0d_addr", i), u_addr, vec[i].eaddr);
      end
      check($sformatf("v%0d_rsp_valid", i), rsp_valid, vec[i].rv);
      if (vec[i].rv) begin
        check($sformatf("v%0d_rsp_data", i), rsp_data, vec[i].rdata);
        check($sformatf("v%0d_rsp_err", i), rsp_err, vec[i].rerr);
      end
      check($sformatf("v%0d_wr_done", i), wr_done, vec[i].wd);
      check($sformatf("v%0d_count", i), q_count, vec[i].cnt);
      check($sformatf("v%0d_ready", i), req_ready, vec[i].rdy);
    end
    u_data_valid = 0;

    // Five pushes against a busy controller, then drain in order.
    u_busy = 1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1; req_cmd = 1; req_addr = 12'(32'h100 + i); req_wdata = 2'(i);
      tick();
      if (i == 2) check("full_ready3", req_ready, 1);
      if (i == 3) begin
        check("full_count4", q_count, 4);
        check("full_ready4", req_ready, 0);
      end
      if (i == 4) check("full_count5", q_count, 4);
    end
    req_valid = 0;
    check("full_no_issue", u_en, 0);
    u_busy = 0;
    for (int i = 0; i < 4; i++) begin
      wait_en();
      check($sformatf("drain%0d_addr", i), u_addr, 32'h100 + i);
      check($sformatf("drain%0d_cmd", i), u_cmd, 1);
      check($sformatf("drain%0d_data", i), u_data_i, i % 4);
      u_cmd_ack = 1;
      tick();
      u_cmd_ack = 0;
      tick();
      check($sformatf("drain%0d_wr_done", i), wr_done, 1);
    end
    check("drain_count", q_count, 0);
    tick();

    // Read with no data returned times out, then the queued write issues.
    req_valid = 1; req_cmd = 0; req_addr = 12'h0A1;
    tick();
    req_cmd = 1; req_addr = 12'h0B2; req_wdata = 1;
    tick();
    req_valid = 0;
    wait_en();
    check("to_rd_cmd", u_cmd, 0);
    check("to_rd_addr", u_addr, 12'h0A1);
    u_cmd_ack = 1;
    tick();
    u_cmd_ack = 0; u_data_o = 3;
    begin
      int k = 0;
      while (!rsp_valid && k < 100) begin
        tick();
        k++;
      end
      check("to_latency", k, 64);
    end
    check("to_err", rsp_err, 1);
    check("to_data", rsp_data, 0);
    check("to_no_wr_done", wr_done, 0);
    tick();
    check("to_next_en", u_en, 1);
    check("to_next_cmd", u_cmd, 1);
    check("to_next_addr", u_addr, 12'h0B2);
    check("to_rsp_clear", rsp_valid, 0);
    u_cmd_ack = 1;
    tick();
    u_cmd_ack = 0;
    tick();
    check("to_wr_done", wr_done, 1);
    tick();

    // Push and ack-pop together at depth 2, then reset mid-read.
    u_busy = 1;
    req_valid = 1; req_cmd = 0; req_addr = 12'h0C0;
    tick();
    req_addr = 12'h0C1;
    tick();
    req_valid = 0;
    check("sim_pre_count", q_count, 2);
    u_busy = 0;
    tick();
    check("sim_en", u_en, 1);
    req_valid = 1; req_addr = 12'h0C2; u_cmd_ack = 1;
    tick();
    req_valid = 0; u_cmd_ack = 0;
    check("sim_count", q_count, 2);
    check("sim_en_low", u_en, 0);
    tick();
    u_rst_n = 0;
    tick();
    check("rst_en", u_en, 0);
    check("rst_addr", u_addr, 0);
    check("rst_data_i", u_data_i, 0);
    check("rst_cmd", u_cmd, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_wr_done", wr_done, 0);
    check("rst_count", q_count, 0);
    check("rst_ready", req_ready, 0);
    u_rst_n = 1; u_data_valid = 1; u_data_o = 3;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post_rst%0d_rsp", i), rsp_valid, 0);
      check($sformatf("post_rst%0d_en", i), u_en, 0);
    end
    check("post_rst_ready", req_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dram_cmd_queue.md
# dram_cmd_queue

- Request front-end sitting directly upstream of `dram_controller`.
- Buffers read/write requests from a client in a small FIFO and issues them one at a time over the controller's `u_en`/`u_busy`/`u_cmd_ack` handshake.
- Returns read data, or a timeout error, on a single-cycle response strobe.
- Lets the client stream requests without tracking controller busy/ack timing.

## Interface
Parameters:
- NUMBER_OF_COLUMNS, 8, columns per row
- NUMBER_OF_ROWS, 128, rows per bank
- NUMBER_OF_BANKS, 8, banks
- U_DATA_WIDTH, 2, data width
- DRAM_DATA_WIDTH, 2, DRAM word width
- QUEUE_DEPTH, 4, FIFO entries, power of 2, ≥2
- RD_TIMEOUT, 64, max cycles from ack to `u_data_valid`
- Derived: U_ADDR_WIDTH = clog2(NUMBER_OF_BANKS) + clog2(NUMBER_OF_ROWS) + clog2(NUMBER_OF_COLUMNS/DRAM_DATA_WIDTH), 12 at defaults

Ports (clock: `u_clk`; reset: `u_rst_n`, synchronous, active-low):
- u_clk  in  1  clock
- u_rst_n  in  1  synchronous active-low reset
- req_valid  in  1  client request valid
- req_ready  out  1  queue can accept
- req_addr  in  U_ADDR_WIDTH  {bank, row, col}
- req_wdata  in  U_DATA_WIDTH  write data
- req_cmd  in  1  1 = write, 0 = read
- rsp_valid  out  1  one-cycle read-response strobe
- rsp_data  out  U_DATA_WIDTH  read data
- rsp_err  out  1  read timed out (qualified by rsp_valid)
- wr_done  out  1  one-cycle write-completion strobe
- q_count  out  clog2(QUEUE_DEPTH+1)  occupancy
- u_en, u_addr, u_data_i, u_cmd  out  1 / U_ADDR_WIDTH / U_DATA_WIDTH / 1  to controller
- u_data_o  in  U_DATA_WIDTH  read data from controller
- u_data_valid, u_cmd_ack, u_busy  in  1 each  from controller

## Operation
FIFO:
- Entry = {cmd, addr, wdata}.
- Push when `req_valid && req_ready`.
- `req_ready = u_rst_n && (q_count != QUEUE_DEPTH)`. No bypass: a pop in the same cycle does not make a full queue ready.
- Simultaneous push and pop leaves `q_count` unchanged.
- Pointers wrap modulo QUEUE_DEPTH.

FSM states: IDLE, ISSUE, WAIT_RD, WAIT_WR.
- IDLE → ISSUE when queue non-empty and `u_busy == 0`. On that edge, register head fields onto `u_addr`/`u_data_i`/`u_cmd` and set `u_en = 1`.
- ISSUE: hold `u_en` and the fields stable until `u_cmd_ack` is sampled 1.
  - On that edge: pop head, clear `u_en`, clear the timeout counter.
  - Next state is WAIT_RD if cmd = 0, otherwise WAIT_WR.
- WAIT_RD:
  - On `u_data_valid`: `rsp_data <= u_data_o`, `rsp_valid <= 1`, `rsp_err <= 0`, go to IDLE.
  - If the counter reaches RD_TIMEOUT first: `rsp_valid <= 1`, `rsp_err <= 1`, `rsp_data <= 0`, go to IDLE.
  - Counter saturates and is reset on ISSUE exit.
- WAIT_WR: enter at least one cycle after ack. On `u_busy == 0`: `wr_done <= 1`, go to IDLE.
- `u_data_valid` seen outside WAIT_RD is ignored.
- `u_busy` rising while in IDLE blocks issue. It does not flush the queue.

## Timing
- All outputs are registered.
- Reset values: req_ready 0 while `u_rst_n` is low; u_en, u_addr, u_data_i, u_cmd, rsp_valid, rsp_data, rsp_err, wr_done, q_count all 0.
- Reset clears the state to IDLE and flushes the FIFO, including mid-transaction; no response is emitted for the in-flight command.
- Push at edge N, with empty queue, IDLE and `u_busy` low: `u_en` is high after edge N+1.
- Ack sampled at edge A: `u_en` low after A, `q_count` decremented after A.
- Read: `rsp_valid` is high for exactly the cycle after the edge that samples `u_data_valid`.
- Back-to-back: the next issue occurs no earlier than the cycle after IDLE re-entry.
- `rsp_valid` and `wr_done` are never high together. At most one command is outstanding.

## Structure
- Package `dram_ctrl_pkg`:
  - derived width functions (COLUMN_WIDTH, ROW_WIDTH, BANK_ID_WIDTH, U_ADDR_WIDTH)
  - CMD_READ = 0, CMD_WRITE = 1
  - FSM state encoding
- Sub-module `dram_req_fifo`: parameterised synchronous FIFO with push/pop/count.
- FSM and timeout counter live in `dram_cmd_queue`.

## Test plan
- Single write, addr 0x2A5, data 2'b10, controller idle → `u_en` high after one edge with `u_addr = 0x2A5`, `u_cmd = 1`; after ack and `u_busy` low, one `wr_done` pulse; `q_count` returns to 0.
- Write 2'b11 to 0x013, then read 0x013 → `rsp_valid` pulse with `rsp_data = 2'b11`, `rsp_err = 0`.
- Push 5 requests back-to-back with `u_busy` held high → `req_ready` low after the 4th push, `q_count = 4`; after `u_busy` drops, the 4 commands issue in FIFO order.
- Read issued, `u_data_valid` never asserted → exactly RD_TIMEOUT cycles after ack, `rsp_valid = 1`, `rsp_err = 1`, `rsp_data = 0`; the next queued command then issues.
- `u_rst_n` low for 1 cycle during WAIT_RD with 2 entries queued → all outputs 0, `q_count = 0`, no `rsp_valid`.
- Simultaneous push and ack-pop with `q_count = 2` → `q_count` stays 2.
